// File: rtl/game_pkg.sv
// Shared encodings for the typing game: FSM states, key scan codes, per-mode value limits.
// The scorer imports the same state constants so both sides agree on INGAME.
package game_pkg;

  typedef enum logic [1:0] {
    ST_SELECT    = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_INGAME    = 2'd2,
    ST_FINISH    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    KEY_NONE  = 3'd0,
    KEY_ENTER = 3'd1,
    KEY_ESC   = 3'd2,
    KEY_M     = 3'd3,
    KEY_INC   = 3'd4,
    KEY_DEC   = 3'd5
  } key_id_e;

  localparam logic [8:0] SC_ENTER = 9'h05A;
  localparam logic [8:0] SC_ESC   = 9'h076;
  localparam logic [8:0] SC_M     = 9'h03A;
  localparam logic [8:0] SC_INC   = 9'h055;
  localparam logic [8:0] SC_DEC   = 9'h04E;

  // Mode 0 is timed (seconds), mode 1 is word count.
  localparam logic [6:0] T_STEP = 7'd15;
  localparam logic [6:0] T_MIN  = 7'd15;
  localparam logic [6:0] T_MAX  = 7'd120;
  localparam logic [6:0] T_DEF  = 7'd30;
  localparam logic [6:0] W_STEP = 7'd5;
  localparam logic [6:0] W_MIN  = 7'd5;
  localparam logic [6:0] W_MAX  = 7'd100;
  localparam logic [6:0] W_DEF  = 7'd25;

  function automatic logic [6:0] step_of(input logic m);
    return m ? W_STEP : T_STEP;
  endfunction

  function automatic logic [6:0] min_of(input logic m);
    return m ? W_MIN : T_MIN;
  endfunction

  function automatic logic [6:0] max_of(input logic m);
    return m ? W_MAX : T_MAX;
  endfunction

  function automatic logic [6:0] def_of(input logic m);
    return m ? W_DEF : T_DEF;
  endfunction

  // The sum is formed one bit wider so 120+15 cannot wrap before the clamp.
  function automatic logic [6:0] value_up(input logic m, input logic [6:0] v);
    logic [7:0] s;
    s = {1'b0, v} + {1'b0, step_of(m)};
    return (s > {1'b0, max_of(m)}) ? max_of(m) : s[6:0];
  endfunction

  function automatic logic [6:0] value_down(input logic m, input logic [6:0] v);
    return (v < (min_of(m) + step_of(m))) ? min_of(m) : (v - step_of(m));
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Keyboard/scorer inputs and game status outputs of game_ctrl.
// master drives the keyboard and scorer side; slave is the sequencer.
interface game_ctrl_if;

  logic [127:0] key_down;
  logic [8:0]   last_change;
  logic         key_valid;
  logic         finish;
  logic [9:0]   wpm_in;
  logic [9:0]   acc_in;
  logic [14:0]  timer_in;

  logic [1:0]   state;
  logic         mode;
  logic [6:0]   value;
  logic [1:0]   cd_sec;
  logic [9:0]   res_wpm;
  logic [9:0]   res_acc;
  logic [14:0]  res_time;
  logic [9:0]   best_wpm;
  logic         new_best;

  modport master (
    output key_down, last_change, key_valid, finish, wpm_in, acc_in, timer_in,
    input  state, mode, value, cd_sec, res_wpm, res_acc, res_time, best_wpm, new_best
  );

  modport slave (
    input  key_down, last_change, key_valid, finish, wpm_in, acc_in, timer_in,
    output state, mode, value, cd_sec, res_wpm, res_acc, res_time, best_wpm, new_best
  );

endinterface

// File: rtl/key_event.sv
// Turns keyboard strobes into single press pulses with a decoded key id; combinational
// from inputs (0 cycles), no backpressure. Chords and typematic repeats are rejected.
module key_event
  import game_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_down_i,
  input  logic [8:0]   last_change_i,
  input  logic         key_valid_i,
  output logic         press_o,
  output key_id_e      key_id_o
);

  logic         held_q;
  logic         held_d;
  logic         in_range;
  logic         cur_down;
  logic         only_one;
  logic [127:0] onehot;

  always_comb begin
    // Codes above 127 have no bit in the bitmap, so they can never be pressed.
    in_range = (last_change_i[8:7] == 2'b00);
    onehot   = 128'd1 << last_change_i[6:0];
    cur_down = in_range && key_down_i[last_change_i[6:0]];
    only_one = ((key_down_i & ~onehot) == '0);
    held_d   = cur_down;
    press_o  = key_valid_i && cur_down && only_one && !held_q;

    key_id_o = KEY_NONE;
    case (last_change_i)
      SC_ENTER: key_id_o = KEY_ENTER;
      SC_ESC:   key_id_o = KEY_ESC;
      SC_M:     key_id_o = KEY_M;
      SC_INC:   key_id_o = KEY_INC;
      SC_DEC:   key_id_o = KEY_DEC;
      default:  key_id_o = KEY_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) held_q <= 1'b0;
    else     held_q <= held_d;
  end

endmodule

// File: rtl/game_ctrl.sv
// Typing-game sequencer: select/countdown/ingame/finish FSM, result latching, per-mode best wpm.
// All outputs registered, 1-cycle latency from press or finish; no backpressure.
module game_ctrl
  import game_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input logic        clk,
  input logic        rst,
  game_ctrl_if.slave io
);

  localparam int            TW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);

  state_e          state_q,    state_d;
  logic            mode_q,     mode_d;
  logic [6:0]      value_q,    value_d;
  logic [1:0]      cd_q,       cd_d;
  logic [TW-1:0]   tick_q,     tick_d;
  logic [9:0]      res_wpm_q,  res_wpm_d;
  logic [9:0]      res_acc_q,  res_acc_d;
  logic [14:0]     res_time_q, res_time_d;
  logic [1:0][9:0] best_q,     best_d;
  logic            new_best_q, new_best_d;

  logic    press;
  key_id_e key_id;

  key_event u_key_event (
    .clk           (clk),
    .rst           (rst),
    .key_down_i    (io.key_down),
    .last_change_i (io.last_change),
    .key_valid_i   (io.key_valid),
    .press_o       (press),
    .key_id_o      (key_id)
  );

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    value_d    = value_q;
    cd_d       = cd_q;
    tick_d     = tick_q;
    res_wpm_d  = res_wpm_q;
    res_acc_d  = res_acc_q;
    res_time_d = res_time_q;
    best_d     = best_q;
    new_best_d = new_best_q;

    // ESC outranks everything, including a finish arriving in the same cycle.
    if (press && key_id == KEY_ESC) begin
      state_d    = ST_SELECT;
      cd_d       = 2'd0;
      tick_d     = '0;
      new_best_d = 1'b0;
    end else begin
      case (state_q)
        ST_SELECT: begin
          if (press) begin
            case (key_id)
              KEY_ENTER: begin
                state_d = ST_COUNTDOWN;
                cd_d    = 2'd3;
                tick_d  = '0;
              end
              KEY_M: begin
                mode_d  = ~mode_q;
                value_d = def_of(~mode_q);
              end
              KEY_INC: value_d = value_up(mode_q, value_q);
              KEY_DEC: value_d = value_down(mode_q, value_q);
              default: ;
            endcase
          end
        end
        ST_COUNTDOWN: begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (cd_q == 2'd1) begin
              state_d = ST_INGAME;
              cd_d    = 2'd0;
            end else begin
              cd_d = cd_q - 2'd1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        ST_INGAME: begin
          if (io.finish) begin
            state_d    = ST_FINISH;
            res_wpm_d  = io.wpm_in;
            res_acc_d  = io.acc_in;
            res_time_d = io.timer_in;
            if (io.wpm_in > best_q[mode_q]) begin
              best_d[mode_q] = io.wpm_in;
              new_best_d     = 1'b1;
            end else begin
              new_best_d = 1'b0;
            end
          end
        end
        ST_FINISH: begin
          if (press && key_id == KEY_ENTER) begin
            state_d    = ST_SELECT;
            new_best_d = 1'b0;
          end
        end
        default: state_d = ST_SELECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SELECT;
      mode_q     <= 1'b0;
      value_q    <= T_DEF;
      cd_q       <= 2'd0;
      tick_q     <= '0;
      res_wpm_q  <= '0;
      res_acc_q  <= '0;
      res_time_q <= '0;
      best_q     <= '0;
      new_best_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      value_q    <= value_d;
      cd_q       <= cd_d;
      tick_q     <= tick_d;
      res_wpm_q  <= res_wpm_d;
      res_acc_q  <= res_acc_d;
      res_time_q <= res_time_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
    end
  end

  assign io.state    = state_q;
  assign io.mode     = mode_q;
  assign io.value    = value_q;
  assign io.cd_sec   = cd_q;
  assign io.res_wpm  = res_wpm_q;
  assign io.res_acc  = res_acc_q;
  assign io.res_time = res_time_q;
  assign io.best_wpm = best_q[mode_q];
  assign io.new_best = new_best_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a cycle-level behavioural model compared every cycle.
module tb_game_ctrl;
  import game_pkg::*;

  localparam int CLK = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  game_ctrl_if io ();

  game_ctrl #(.CLK_HZ(CLK)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: game state as plain integers; countdown derived from cycles since entry.
  int             m_state, m_mode, m_value, m_cd, m_elapsed;
  int             m_rwpm, m_racc, m_rtime, m_nb;
  int             m_best [2];
  logic [127:0]   m_prev_kd;

  task automatic model_step();
    int kc, stp, lo, hi;
    bit pr;
    if (rst) begin
      m_state = 0; m_mode = 0; m_value = 30; m_cd = 0; m_elapsed = 0;
      m_rwpm = 0; m_racc = 0; m_rtime = 0; m_nb = 0;
      m_best[0] = 0; m_best[1] = 0; m_prev_kd = '0;
      return;
    end
    kc  = int'(io.last_change);
    pr  = io.key_valid && (kc < 128) && (io.key_down == (128'd1 << kc)) && !m_prev_kd[kc % 128];
    stp = m_mode ? 5 : 15;
    lo  = m_mode ? 5 : 15;
    hi  = m_mode ? 100 : 120;
    if (pr && kc == 'h76) begin
      m_state = 0; m_cd = 0; m_nb = 0;
    end else begin
      case (m_state)
        0: if (pr) begin
          if (kc == 'h5A) begin m_state = 1; m_cd = 3; m_elapsed = 0; end
          else if (kc == 'h3A) begin m_mode = 1 - m_mode; m_value = m_mode ? 25 : 30; end
          else if (kc == 'h55) m_value = (m_value + stp > hi) ? hi : m_value + stp;
          else if (kc == 'h4E) m_value = (m_value - stp < lo) ? lo : m_value - stp;
        end
        1: begin
          m_elapsed++;
          if (m_elapsed == 3 * CLK) begin m_state = 2; m_cd = 0; end
          else m_cd = 3 - m_elapsed / CLK;
        end
        2: if (io.finish) begin
          m_state = 3;
          m_rwpm = int'(io.wpm_in); m_racc = int'(io.acc_in); m_rtime = int'(io.timer_in);
          if (int'(io.wpm_in) > m_best[m_mode]) begin m_best[m_mode] = int'(io.wpm_in); m_nb = 1; end
          else m_nb = 0;
        end
        default: if (pr && kc == 'h5A) begin m_state = 0; m_nb = 0; end
      endcase
    end
    m_prev_kd = io.key_down;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    chk("state",    int'(io.state),    m_state);
    chk("mode",     int'(io.mode),     m_mode);
    chk("value",    int'(io.value),    m_value);
    chk("cd_sec",   int'(io.cd_sec),   m_cd);
    chk("res_wpm",  int'(io.res_wpm),  m_rwpm);
    chk("res_acc",  int'(io.res_acc),  m_racc);
    chk("res_time", int'(io.res_time), m_rtime);
    chk("best_wpm", int'(io.best_wpm), m_best[m_mode]);
    chk("new_best", int'(io.new_best), m_nb);
  end

  task automatic press_key(input logic [8:0] code);
    @(negedge clk);
    io.key_down = '0; io.key_down[code[6:0]] = 1'b1; io.last_change = code; io.key_valid = 1'b1;
    @(negedge clk);
    io.key_down = '0; io.key_valid = 1'b1;
    @(negedge clk);
    io.key_valid = 1'b0;
  endtask

  task automatic hold_key(input logic [8:0] code, input int strobes);
    for (int i = 0; i < strobes; i++) begin
      @(negedge clk);
      io.key_down = '0; io.key_down[code[6:0]] = 1'b1; io.last_change = code; io.key_valid = 1'b1;
      @(negedge clk);
      io.key_valid = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    io.key_down = '0; io.key_valid = 1'b1;
    @(negedge clk);
    io.key_valid = 1'b0;
  endtask

  // ENTER strobe, then walk the countdown cycle by cycle up to INGAME.
  task automatic run_countdown();
    @(negedge clk);
    io.key_down = '0; io.key_down[SC_ENTER[6:0]] = 1'b1; io.last_change = SC_ENTER; io.key_valid = 1'b1;
    @(negedge clk);
    io.key_down = '0; io.key_valid = 1'b0;
    chk("cd_entry_state", int'(io.state), 1);
    for (int d = 3; d >= 1; d--) begin
      repeat (CLK - 1) @(negedge clk);
      chk("cd_hold", int'(io.cd_sec), d);
      @(negedge clk);
      chk("cd_next", int'(io.cd_sec), d - 1);
    end
    chk("cd_ingame", int'(io.state), 2);
  endtask

  task automatic finish_pulse(input int wpm, input int acc, input int tim);
    @(negedge clk);
    io.finish = 1'b1; io.wpm_in = 10'(wpm); io.acc_in = 10'(acc); io.timer_in = 15'(tim);
    @(negedge clk);
    io.finish = 1'b0; io.wpm_in = 10'd500; io.acc_in = 10'd1; io.timer_in = 15'd7;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    io.key_down = '0; io.last_change = '0; io.key_valid = 1'b0;
    io.finish = 1'b0; io.wpm_in = '0; io.acc_in = '0; io.timer_in = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_state", int'(io.state), 0);
    chk("rst_value", int'(io.value), 30);
    chk("rst_best",  int'(io.best_wpm), 0);

    repeat (7) press_key(SC_INC);
    chk("inc_sat", int'(io.value), 120);
    repeat (9) press_key(SC_DEC);
    chk("dec_sat", int'(io.value), 15);
    press_key(SC_M);
    chk("m_mode", int'(io.mode), 1);
    chk("m_value", int'(io.value), 25);
    press_key(SC_INC);
    chk("w_inc", int'(io.value), 30);
    press_key(SC_M);
    chk("m_back_mode", int'(io.mode), 0);
    press_key(9'h01C);
    chk("unknown_value", int'(io.value), 30);

    finish_pulse(77, 50, 100);
    chk("fin_in_select", int'(io.state), 0);
    chk("fin_in_select_res", int'(io.res_wpm), 0);

    @(negedge clk);
    io.key_down = '0; io.key_down[SC_ENTER[6:0]] = 1'b1; io.key_down[7'h1C] = 1'b1;
    io.last_change = SC_ENTER; io.key_valid = 1'b1;
    @(negedge clk);
    io.key_valid = 1'b0; io.key_down = '0;
    chk("chord_reject", int'(io.state), 0);
    @(negedge clk);

    hold_key(SC_INC, 3);
    chk("held_inc_once", int'(io.value), 45);
    press_key(SC_DEC);

    run_countdown();
    finish_pulse(42, 95, 3000);
    chk("g1_state", int'(io.state), 3);
    chk("g1_wpm",   int'(io.res_wpm), 42);
    chk("g1_acc",   int'(io.res_acc), 95);
    chk("g1_time",  int'(io.res_time), 3000);
    chk("g1_nb",    int'(io.new_best), 1);
    chk("g1_best",  int'(io.best_wpm), 42);

    hold_key(SC_ENTER, 3);
    chk("held_enter_once", int'(io.state), 0);
    chk("keep_res", int'(io.res_wpm), 42);

    run_countdown();
    finish_pulse(30, 80, 2500);
    chk("g2_nb",   int'(io.new_best), 0);
    chk("g2_best", int'(io.best_wpm), 42);
    chk("g2_wpm",  int'(io.res_wpm), 30);
    press_key(SC_ENTER);

    @(negedge clk);
    io.key_down = '0; io.key_down[SC_ENTER[6:0]] = 1'b1; io.last_change = SC_ENTER; io.key_valid = 1'b1;
    @(negedge clk);
    io.key_down = '0; io.key_valid = 1'b0;
    repeat (CLK) @(negedge clk);
    chk("esc_pre_cd", int'(io.cd_sec), 2);
    press_key(SC_ESC);
    chk("esc_state", int'(io.state), 0);
    chk("esc_cd", int'(io.cd_sec), 0);

    run_countdown();
    @(negedge clk);
    io.key_down = '0; io.key_down[SC_ESC[6:0]] = 1'b1; io.last_change = SC_ESC; io.key_valid = 1'b1;
    io.finish = 1'b1; io.wpm_in = 10'd99;
    @(negedge clk);
    io.key_down = '0; io.key_valid = 1'b0; io.finish = 1'b0;
    chk("escfin_state", int'(io.state), 0);
    chk("escfin_res", int'(io.res_wpm), 30);
    chk("escfin_best", int'(io.best_wpm), 42);

    press_key(SC_M);
    run_countdown();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_state", int'(io.state), 0);
    chk("midrst_mode",  int'(io.mode), 0);
    chk("midrst_value", int'(io.value), 30);
    chk("midrst_res",   int'(io.res_wpm), 0);
    chk("midrst_best",  int'(io.best_wpm), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
